// File: rtl/bus_select_controller.sv
// ---------------------------------------------------------------------------
// bus_select_controller
//
// Parametrised 68000 bus decode: NUM_CS chip-select regions, each with its
// own base, compare mask and wait-state count. Generates chip selects,
// read output enable, DTACK, a bus-error timeout and autovector acknowledge
// for interrupt-acknowledge cycles. All outputs are registered.
//
// Optional feature macro: BUS_SINGLE_STEP_EN
//   defined   : DATA_ACK additionally waits for a rising edge of the
//               synchronised STEP_IN seen after CS assertion.
//   undefined : STEP_IN is ignored.
//
// Ports:
//   MCLK_IN            in   system clock
//   RESET_IN           in   synchronous active-high reset
//   AS_IN              in   address strobe (active high, asynchronous)
//   WR_IN              in   1 = write, 0 = read
//   UDS_IN / LDS_IN    in   upper / lower data strobes (active high)
//   MPU_STATUS_CODE_IN in   CPU function code FC[2:0]
//   ADDR_IN            in   24-bit CPU address
//   STEP_IN            in   single-step pulse (optional feature only)
//   CS                 out  one-hot chip selects
//   OUTPUT_ENABLE      out  read output enable
//   DATA_ACK           out  DTACK
//   BUS_ERROR_ACK      out  BERR
//   INT_AUTOVEC_ACK    out  AVEC
//
// State table:
//   ST_RELEASE | after reset; wait for synchronised AS low
//   ST_IDLE    | wait for strobe
//   ST_DECODE  | sample address/strobes/FC, drive selects
//   ST_WAIT    | wait-state countdown, CS held
//   ST_STEP    | wait count done, waiting for step edge (optional feature)
//   ST_ACK     | DATA_ACK high, CS/OE held
//   ST_TIMEOUT | unmatched cycle, countdown to BUS_ERROR_ACK (then held)
//   ST_IACK    | INT_AUTOVEC_ACK held
// ---------------------------------------------------------------------------
module bus_select_controller #(
    parameter int                   NUM_CS         = 4,
    parameter logic [NUM_CS*24-1:0] CS_BASE        = {NUM_CS{24'h0}},
    parameter logic [NUM_CS*24-1:0] CS_MASK        = {NUM_CS{24'hF00000}},
    parameter logic [NUM_CS*4-1:0]  CS_WAIT        = {NUM_CS{4'd1}},
    parameter int                   TIMEOUT_CYCLES = 255
) (
    input  logic              MCLK_IN,
    input  logic              RESET_IN,
    input  logic              AS_IN,
    input  logic              WR_IN,
    input  logic              UDS_IN,
    input  logic              LDS_IN,
    input  logic [2:0]        MPU_STATUS_CODE_IN,
    input  logic [23:0]       ADDR_IN,
    input  logic              STEP_IN,
    output logic [NUM_CS-1:0] CS,
    output logic              OUTPUT_ENABLE,
    output logic              DATA_ACK,
    output logic              BUS_ERROR_ACK,
    output logic              INT_AUTOVEC_ACK
);

    localparam logic [9:0] TIMEOUT_LOAD = 10'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_RELEASE,
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_STEP,
        ST_ACK,
        ST_TIMEOUT,
        ST_IACK
    } state_t;

    state_t            state;
    logic [NUM_CS-1:0] cs_q;
    logic              oe_q;
    logic              dack_q;
    logic              berr_q;
    logic              avec_q;
    logic [9:0]        cnt;

    // -----------------------------------------------------------------------
    // AS synchroniser. Both stages reset high so a strobe that is already
    // asserted during reset can never be mistaken for a fresh cycle: the
    // block only leaves RELEASE once a real low has propagated through.
    // -----------------------------------------------------------------------
    logic as_meta;
    logic as_sync;

    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            as_meta <= 1'b1;
            as_sync <= 1'b1;
        end else begin
            as_meta <= AS_IN;
            as_sync <= as_meta;
        end
    end

`ifdef BUS_SINGLE_STEP_EN
    logic step_meta;
    logic step_sync;
    logic step_prev;
    logic step_rise;
    logic step_seen;

    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_meta <= STEP_IN;
            step_sync <= step_meta;
            step_prev <= step_sync;
        end
    end

    assign step_rise = step_sync & ~step_prev;
`else
    logic unused_step;
    assign unused_step = STEP_IN;
`endif

    // -----------------------------------------------------------------------
    // Region decode. Iterating from the top index down lets the lowest
    // matching region overwrite any higher one.
    // -----------------------------------------------------------------------
    logic              hit;
    logic [2:0]        hit_idx;
    logic [NUM_CS-1:0] hit_cs;
    logic [3:0]        hit_wait;

    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if ((ADDR_IN & CS_MASK[24*i +: 24]) == CS_BASE[24*i +: 24]) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    assign hit_cs   = NUM_CS'(1) << hit_idx;
    assign hit_wait = CS_WAIT[4*hit_idx +: 4];

    // -----------------------------------------------------------------------
    // Bus cycle FSM.
    // IDLE exits on the first synchroniser stage so that DECODE samples the
    // bus on the second edge after the strobe, keeping select latency at two
    // edges. Abort and RELEASE use the fully synchronised strobe, so a
    // strobe drop clears outputs on the second edge after it is sampled.
    // The bus fields are sampled only in DECODE; everything afterwards works
    // from registered results, so late bus changes have no effect.
    // -----------------------------------------------------------------------
    always_ff @(posedge MCLK_IN) begin
        if (RESET_IN) begin
            state  <= ST_RELEASE;
            cs_q   <= '0;
            oe_q   <= 1'b0;
            dack_q <= 1'b0;
            berr_q <= 1'b0;
            avec_q <= 1'b0;
            cnt    <= 10'd0;
`ifdef BUS_SINGLE_STEP_EN
            step_seen <= 1'b0;
`endif
        end else if (state == ST_RELEASE) begin
            if (!as_sync) begin
                state <= ST_IDLE;
            end
        end else if (state == ST_IDLE) begin
            if (as_meta) begin
                state <= ST_DECODE;
            end
        end else if (!as_sync) begin
            // strobe dropped: finished or aborted cycle
            state  <= ST_IDLE;
            cs_q   <= '0;
            oe_q   <= 1'b0;
            dack_q <= 1'b0;
            berr_q <= 1'b0;
            avec_q <= 1'b0;
            cnt    <= 10'd0;
        end else begin
            case (state)
                ST_DECODE: begin
`ifdef BUS_SINGLE_STEP_EN
                    step_seen <= 1'b0;
`endif
                    if (MPU_STATUS_CODE_IN == 3'b111) begin
                        avec_q <= 1'b1;
                        state  <= ST_IACK;
                    end else if (hit) begin
                        cs_q <= hit_cs;
                        oe_q <= ~WR_IN & (UDS_IN | LDS_IN);
                        cnt  <= {6'd0, hit_wait};
                        if (hit_wait == 4'd0) begin
`ifdef BUS_SINGLE_STEP_EN
                            state <= ST_STEP;
`else
                            dack_q <= 1'b1;
                            state  <= ST_ACK;
`endif
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else begin
                        cnt   <= TIMEOUT_LOAD;
                        state <= ST_TIMEOUT;
                    end
                end

                ST_WAIT: begin
                    cnt <= cnt - 10'd1;
`ifdef BUS_SINGLE_STEP_EN
                    if (step_rise) begin
                        step_seen <= 1'b1;
                    end
                    if (cnt == 10'd1) begin
                        if (step_seen || step_rise) begin
                            dack_q <= 1'b1;
                            state  <= ST_ACK;
                        end else begin
                            state <= ST_STEP;
                        end
                    end
`else
                    if (cnt == 10'd1) begin
                        dack_q <= 1'b1;
                        state  <= ST_ACK;
                    end
`endif
                end

`ifdef BUS_SINGLE_STEP_EN
                ST_STEP: begin
                    if (step_rise || step_seen) begin
                        dack_q <= 1'b1;
                        state  <= ST_ACK;
                    end
                end
`endif

                ST_TIMEOUT: begin
                    // counter parks at zero with BERR held
                    if (cnt == 10'd1) begin
                        berr_q <= 1'b1;
                        cnt    <= 10'd0;
                    end else if (cnt != 10'd0) begin
                        cnt <= cnt - 10'd1;
                    end
                end

                default: begin
                    // ST_ACK, ST_IACK: hold until the strobe drops
                end
            endcase
        end
    end

    assign CS              = cs_q;
    assign OUTPUT_ENABLE   = oe_q;
    assign DATA_ACK        = dack_q;
    assign BUS_ERROR_ACK   = berr_q;
    assign INT_AUTOVEC_ACK = avec_q;

endmodule

// File: tb/tb_bus_select_controller.sv
// ---------------------------------------------------------------------------
// tb_bus_select_controller
//
// Directed, table-driven bench for bus_select_controller. Region map:
//   r0 base 000000 mask F00000 wait 2
//   r1 base 100000 mask F00000 wait 10
//   r2 base 200000 mask F00000 wait 0
//   r3 base 100000 mask FF0000 wait 3  (overlaps r1, never wins)
// TIMEOUT_CYCLES = 16.
// Output bundle compared as {CS[3:0], OE, DATA_ACK, BERR, AVEC}.
// ---------------------------------------------------------------------------
module tb_bus_select_controller;

    logic        clk;
    logic        rst;
    logic        as_s;
    logic        wr;
    logic        uds;
    logic        lds;
    logic [2:0]  fc;
    logic [23:0] addr;
    logic        step;
    logic [3:0]  cs;
    logic        oe;
    logic        dack;
    logic        berr;
    logic        avec;
    logic [7:0]  outs;

    int checks   = 0;
    int failures = 0;

    bus_select_controller #(
        .NUM_CS         (4),
        .CS_BASE        ({24'h100000, 24'h200000, 24'h100000, 24'h000000}),
        .CS_MASK        ({24'hFF0000, 24'hF00000, 24'hF00000, 24'hF00000}),
        .CS_WAIT        ({4'd3, 4'd0, 4'd10, 4'd2}),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .MCLK_IN            (clk),
        .RESET_IN           (rst),
        .AS_IN              (as_s),
        .WR_IN              (wr),
        .UDS_IN             (uds),
        .LDS_IN             (lds),
        .MPU_STATUS_CODE_IN (fc),
        .ADDR_IN            (addr),
        .STEP_IN            (step),
        .CS                 (cs),
        .OUTPUT_ENABLE      (oe),
        .DATA_ACK           (dack),
        .BUS_ERROR_ACK      (berr),
        .INT_AUTOVEC_ACK    (avec)
    );

    assign outs = {cs, oe, dack, berr, avec};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // kind: 0 data ack, 1 bus error, 2 autovector
    typedef struct {
        logic [23:0] a;
        logic        w;
        logic        u;
        logic        l;
        logic [2:0]  f;
        logic [3:0]  ecs;
        logic        eoe;
        int          kind;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] pre;
        logic [7:0] acked;
        string      tag;
        tag   = $sformatf("v%0d", idx);
        pre   = {v.ecs, v.eoe, 3'b000};
        acked = {v.ecs, v.eoe, (v.kind == 0), (v.kind == 1), (v.kind == 2)};
        addr  = v.a;
        wr    = v.w;
        uds   = v.u;
        lds   = v.l;
        fc    = v.f;
        as_s  = 1'b1;
        tick(2);
        check({tag, "_e1_quiet"}, outs, 8'h00);
        tick(1);
`ifdef BUS_SINGLE_STEP_EN
        if (v.kind == 0) begin
            bit got;
            check({tag, "_e2"}, outs, pre);
            tick(v.lat + 2);
            check({tag, "_step_hold"}, outs, pre);
            step = 1'b1;
            got  = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                tick(1);
                if (dack) got = 1'b1;
            end
            step = 1'b0;
            check({tag, "_step_ack"}, outs, acked);
        end else
`endif
        if (v.lat == 0) begin
            check({tag, "_e2"}, outs, acked);
        end else begin
            check({tag, "_e2"}, outs, pre);
            if (v.lat > 1) tick(v.lat - 1);
            check({tag, "_before_ack"}, outs, pre);
            tick(1);
            check({tag, "_ack"}, outs, acked);
        end
        // late bus changes must be ignored
        addr = 24'hF00000;
        wr   = ~v.w;
        uds  = 1'b0;
        lds  = 1'b0;
        fc   = 3'b000;
        tick(2);
        check({tag, "_latched"}, outs, acked);
        as_s = 1'b0;
        tick(2);
        check({tag, "_drop_hold"}, outs, acked);
        tick(1);
        check({tag, "_drop_clear"}, outs, 8'h00);
        tick(2);
    endtask

    initial begin
        bit seen;

        vecs[0] = '{24'h001234, 1'b0, 1'b1, 1'b1, 3'b101, 4'b0001, 1'b1, 0, 2};
        vecs[1] = '{24'h200010, 1'b1, 1'b1, 1'b1, 3'b101, 4'b0100, 1'b0, 0, 0};
        vecs[2] = '{24'h200020, 1'b0, 1'b1, 1'b0, 3'b110, 4'b0100, 1'b1, 0, 0};
        vecs[3] = '{24'h0ABCDE, 1'b0, 1'b0, 1'b1, 3'b001, 4'b0001, 1'b1, 0, 2};
        vecs[4] = '{24'h000100, 1'b0, 1'b0, 1'b0, 3'b101, 4'b0001, 1'b0, 0, 2};
        vecs[5] = '{24'hF00000, 1'b0, 1'b1, 1'b1, 3'b101, 4'b0000, 1'b0, 1, 16};
        vecs[6] = '{24'h000006, 1'b0, 1'b1, 1'b1, 3'b111, 4'b0000, 1'b0, 2, 0};
        vecs[7] = '{24'h101234, 1'b0, 1'b1, 1'b1, 3'b101, 4'b0010, 1'b1, 0, 10};

        rst  = 1'b1;
        as_s = 1'b0;
        wr   = 1'b0;
        uds  = 1'b0;
        lds  = 1'b0;
        fc   = 3'b000;
        addr = 24'h000000;
        step = 1'b0;
        tick(3);
        check("reset_state", outs, 8'h00);
        rst = 1'b0;
        tick(5);
        check("idle_after_reset", outs, 8'h00);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // abort in the middle of a 10-state wait
        addr = 24'h101234; wr = 1'b0; uds = 1'b1; lds = 1'b1; fc = 3'b101;
        as_s = 1'b1;
        tick(3);
        check("midwait_cs", outs, {4'b0010, 1'b1, 3'b000});
        tick(4);
        as_s = 1'b0;
        tick(2);
        check("midwait_hold", outs, {4'b0010, 1'b1, 3'b000});
        tick(1);
        check("midwait_clear", outs, 8'h00);
        seen = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick(1);
            if (outs != 8'h00) seen = 1'b1;
        end
        check("midwait_no_late_ack", {7'd0, seen}, 8'h00);
        addr = 24'h000010;
        as_s = 1'b1;
        tick(3);
        check("idle_after_abort", outs, {4'b0001, 1'b1, 3'b000});
        as_s = 1'b0;
        tick(3);
        check("idle_after_abort_clear", outs, 8'h00);

        // abort in the middle of a timeout
        addr = 24'hF00000;
        as_s = 1'b1;
        tick(8);
        check("midtimeout_quiet", outs, 8'h00);
        as_s = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (berr) seen = 1'b1;
        end
        check("midtimeout_no_berr", {7'd0, seen}, 8'h00);

        // reset while AS is held high
        addr = 24'h000020;
        as_s = 1'b1;
        tick(3);
        check("pre_reset_cs", outs, {4'b0001, 1'b1, 3'b000});
        rst = 1'b1;
        tick(1);
        check("reset_with_as", outs, 8'h00);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (outs != 8'h00) seen = 1'b1;
        end
        check("no_cycle_after_reset", {7'd0, seen}, 8'h00);
        as_s = 1'b0;
        tick(4);
        as_s = 1'b1;
        tick(3);
        check("cycle_after_release", outs, {4'b0001, 1'b1, 3'b000});
        as_s = 1'b0;
        tick(3);
        check("final_clear", outs, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
